// File: rtl/reloj_min_hora_if.sv
// Control and display bus of the minutes/hours stage.
// The master drives the tick, mode and buttons; the slave returns the BCD digits and the day pulse.
interface reloj_min_hora_if;
    logic       tick;
    logic       en_set;
    logic       btn_min;
    logic       btn_hr;
    logic [3:0] min_u;
    logic [3:0] min_t;
    logic [3:0] hr_u;
    logic [3:0] hr_t;
    logic       dia;

    modport master (
        output tick, en_set, btn_min, btn_hr,
        input  min_u, min_t, hr_u, hr_t, dia
    );

    modport slave (
        input  tick, en_set, btn_min, btn_hr,
        output min_u, min_t, hr_u, hr_t, dia
    );
endinterface

// File: rtl/reloj_min_hora.sv
// BCD minutes/hours counter with tick edge detection and a button-driven set mode.
// All state changes on the falling edge of clk; rst clears everything asynchronously.
module reloj_min_hora (
    input  logic             clk,
    input  logic             rst,
    reloj_min_hora_if.slave  bus
);
    localparam int unsigned DW = 4;
    localparam int unsigned SW = 3;

    logic [DW-1:0] min_u_q, min_u_d;
    logic [DW-1:0] min_t_q, min_t_d;
    logic [DW-1:0] hr_u_q,  hr_u_d;
    logic [DW-1:0] hr_t_q,  hr_t_d;
    logic          dia_q,   dia_d;
    logic          tick_q;
    logic [SW-1:0] bm_q, bh_q;

    logic adv, push_min, push_hr, min_inc, min_carry, hr_inc, hr_wrap;

    // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge flop).
    assign adv      = bus.tick & ~tick_q & ~bus.en_set;
    assign push_min = bm_q[1] & ~bm_q[2] & bus.en_set;
    assign push_hr  = bh_q[1] & ~bh_q[2] & bus.en_set;

    assign hr_wrap  = (hr_t_q == DW'(2)) && (hr_u_q == DW'(3));

    always_comb begin
        min_u_d   = min_u_q;
        min_t_d   = min_t_q;
        hr_u_d    = hr_u_q;
        hr_t_d    = hr_t_q;
        dia_d     = 1'b0;
        min_carry = 1'b0;
        min_inc   = adv | push_min;

        if (min_inc) begin
            if (min_u_q != DW'(9)) begin
                min_u_d = min_u_q + DW'(1);
            end else begin
                min_u_d = '0;
                if (min_t_q != DW'(5)) begin
                    min_t_d = min_t_q + DW'(1);
                end else begin
                    min_t_d   = '0;
                    min_carry = 1'b1;
                end
            end
        end

        // Carry out of minutes only counts in run mode; set-mode minute pushes wrap locally.
        hr_inc = (adv & min_carry) | push_hr;
        if (hr_inc) begin
            if (hr_wrap) begin
                hr_u_d = '0;
                hr_t_d = '0;
                dia_d  = adv & min_carry;
            end else if (hr_u_q == DW'(9)) begin
                hr_u_d = '0;
                hr_t_d = hr_t_q + DW'(1);
            end else begin
                hr_u_d = hr_u_q + DW'(1);
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            min_u_q <= '0;
            min_t_q <= '0;
            hr_u_q  <= '0;
            hr_t_q  <= '0;
            dia_q   <= 1'b0;
            tick_q  <= 1'b0;
            bm_q    <= '0;
            bh_q    <= '0;
        end else begin
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
            hr_u_q  <= hr_u_d;
            hr_t_q  <= hr_t_d;
            dia_q   <= dia_d;
            tick_q  <= bus.tick;
            bm_q    <= {bm_q[SW-2:0], bus.btn_min};
            bh_q    <= {bh_q[SW-2:0], bus.btn_hr};
        end
    end

    assign bus.min_u = min_u_q;
    assign bus.min_t = min_t_q;
    assign bus.hr_u  = hr_u_q;
    assign bus.hr_t  = hr_t_q;
    assign bus.dia   = dia_q;
endmodule

// File: tb/tb_reloj_min_hora.sv
// Directed bench for reloj_min_hora: inputs change and outputs are sampled on the rising edge,
// half a period away from the falling edge where the design updates.
module tb_reloj_min_hora;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   dia_cnt;
    int   dia_base;

    reloj_min_hora_if bus ();

    reloj_min_hora dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every rising-edge sample at which dia is high.
    always @(posedge clk) begin
        if (bus.dia === 1'b1) dia_cnt <= dia_cnt + 1;
    end

    function automatic logic [15:0] hhmm();
        return {bus.hr_t, bus.hr_u, bus.min_t, bus.min_u};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic tick_pulse();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        cyc(5);
    endtask

    task automatic press(input logic m, input logic h);
        bus.btn_min = m;
        bus.btn_hr  = h;
        cyc(3);
        bus.btn_min = 1'b0;
        bus.btn_hr  = 1'b0;
        cyc(4);
    endtask

    task automatic press_n(input logic m, input logic h, input int n);
        for (int i = 0; i < n; i++) press(m, h);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        dia_cnt = 0;
        rst         = 1'b1;
        bus.tick    = 1'b0;
        bus.en_set  = 1'b0;
        bus.btn_min = 1'b0;
        bus.btn_hr  = 1'b0;
        cyc(3);
        chk("reset_digits", hhmm(), 16'h0000);
        chk("reset_dia", 16'(bus.dia), 16'h0000);
        rst = 1'b0;
        cyc(2);

        for (int i = 0; i < 10; i++) tick_pulse();
        chk("ten_ticks", hhmm(), 16'h0010);
        chk("ten_ticks_dia", 16'(dia_cnt), 16'h0000);

        bus.tick = 1'b1;
        cyc(1);
        chk("long_tick_first_edge", hhmm(), 16'h0011);
        cyc(19);
        bus.tick = 1'b0;
        cyc(3);
        chk("long_tick_once", hhmm(), 16'h0011);

        press(1'b1, 1'b0);
        chk("run_button_ignored", hhmm(), 16'h0011);

        bus.en_set = 1'b1;
        cyc(2);
        press_n(1'b1, 1'b0, 48);
        chk("set_to_0059", hhmm(), 16'h0059);
        press(1'b1, 1'b0);
        chk("set_min_wrap_no_carry", hhmm(), 16'h0000);

        dia_base = dia_cnt;
        press_n(1'b0, 1'b1, 24);
        chk("set_hr_24_presses", hhmm(), 16'h0000);
        chk("set_hr_no_dia", 16'(dia_cnt - dia_base), 16'h0000);

        for (int i = 0; i < 3; i++) tick_pulse();
        chk("tick_in_set_ignored", hhmm(), 16'h0000);

        press_n(1'b1, 1'b1, 9);
        chk("set_to_0909", hhmm(), 16'h0909);
        bus.btn_min = 1'b1;
        bus.btn_hr  = 1'b1;
        cyc(1);
        chk("simul_after_e1", hhmm(), 16'h0909);
        cyc(1);
        chk("simul_after_e2", hhmm(), 16'h0909);
        cyc(1);
        chk("simul_after_e3", hhmm(), 16'h1010);
        bus.btn_min = 1'b0;
        bus.btn_hr  = 1'b0;
        cyc(4);

        press_n(1'b0, 1'b1, 13);
        press_n(1'b1, 1'b0, 49);
        chk("set_to_2359", hhmm(), 16'h2359);

        // tick rises in set mode and is still high after leaving it
        bus.tick = 1'b1;
        cyc(3);
        bus.en_set = 1'b0;
        cyc(3);
        chk("tick_held_leaving_set", hhmm(), 16'h2359);
        bus.tick = 1'b0;
        cyc(3);

        dia_base = dia_cnt;
        bus.tick = 1'b1;
        cyc(1);
        chk("rollover_digits", hhmm(), 16'h0000);
        chk("rollover_dia_high", 16'(bus.dia), 16'h0001);
        bus.tick = 1'b0;
        cyc(1);
        chk("rollover_dia_low", 16'(bus.dia), 16'h0000);
        cyc(5);
        chk("rollover_dia_one_cycle", 16'(dia_cnt - dia_base), 16'h0001);

        bus.en_set = 1'b1;
        cyc(2);
        press_n(1'b0, 1'b1, 12);
        press_n(1'b1, 1'b0, 34);
        bus.en_set = 1'b0;
        cyc(2);
        chk("set_to_1234", hhmm(), 16'h1234);

        #2 rst = 1'b1;
        #1;
        chk("async_reset_digits", hhmm(), 16'h0000);
        chk("async_reset_dia", 16'(bus.dia), 16'h0000);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        chk("after_reset_hold", hhmm(), 16'h0000);
        tick_pulse();
        chk("after_reset_tick", hhmm(), 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
